// File: rtl/counter_pkg.sv
// Shared definitions for the lab counter family: FSM state encoding and default width.
// Input priority on every edge is clr > load > FSM/count; rst overrides everything asynchronously.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/up_count_sequencer_tick_div.sv
// Enable prescaler: step_tick is high on every PRESCALE-th enabled cycle.
// sync_clr forces the phase back to zero so every run starts with a full period.
module tick_div #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic step_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] TERM = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic          at_term;

    // With PRESCALE=1 the phase never leaves zero, so every enabled cycle is a step.
    assign at_term   = (cnt_q == TERM);
    assign step_tick = en & ~sync_clr & at_term;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (sync_clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= at_term ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/up_count_sequencer.sv
// Programmable up counter with wrap or one-shot stop at a limit, prescaled stepping,
// parallel load, synchronous clear, terminal-count pulse and sticky overflow.
module up_count_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             one_shot,
    output logic [WIDTH-1:0] qOut,
    output logic             tc,
    output logic             done,
    output logic             ovf
);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             done_q;
    logic             ovf_q;

    logic             step_tick;
    logic             sync_clr;
    logic [WIDTH-1:0] count_inc;
    logic             at_limit;
    logic             next_is_limit;
    logic             at_max;

    // The prescaler only runs while the FSM is in RUN and nothing overrides the count.
    assign sync_clr = clr | load | (state_q != ST_RUN);

    tick_div #(
        .PRESCALE (PRESCALE)
    ) u_tick_div (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync_clr  (sync_clr),
        .step_tick (step_tick)
    );

    assign count_inc     = count_q + 1'b1;
    assign at_limit      = (count_q == limit);
    assign next_is_limit = (count_inc == limit);
    assign at_max        = &count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so the default below is simply
            // overridden by a later assignment in the same edge rather than racing it.
            tc_q <= 1'b0;
            if (clr) begin
                state_q <= ST_IDLE;
                count_q <= '0;
                done_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end else if (load) begin
                state_q <= ST_IDLE;
                count_q <= load_val;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (en) state_q <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (!en) begin
                            state_q <= ST_IDLE;
                        end else if (step_tick) begin
                            if (one_shot && (at_limit || next_is_limit)) begin
                                count_q <= limit;
                                tc_q    <= 1'b1;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end else if (!one_shot && at_limit) begin
                                // A wrap at the all-ones limit is also a natural rollover.
                                count_q <= '0;
                                tc_q    <= 1'b1;
                                if (at_max) ovf_q <= 1'b1;
                            end else begin
                                count_q <= count_inc;
                                if (at_max) ovf_q <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign qOut = count_q;
    assign tc   = tc_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_up_count_sequencer.sv
// Directed bench for up_count_sequencer: a PRESCALE=1 instance (a) and a PRESCALE=4 instance (b).
module tb_up_count_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       en_a = 0, clr_a = 0, load_a = 0, one_shot_a = 0;
    logic [3:0] load_val_a = '0, limit_a = 4'd15;
    logic [3:0] q_a;
    logic       tc_a, done_a, ovf_a;

    logic       en_b = 0, clr_b = 0, load_b = 0, one_shot_b = 0;
    logic [3:0] load_val_b = '0, limit_b = 4'd15;
    logic [3:0] q_b;
    logic       tc_b, done_b, ovf_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    up_count_sequencer #(.WIDTH(4), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .clr(clr_a), .load(load_a),
        .load_val(load_val_a), .limit(limit_a), .one_shot(one_shot_a),
        .qOut(q_a), .tc(tc_a), .done(done_a), .ovf(ovf_a)
    );

    up_count_sequencer #(.WIDTH(4), .PRESCALE(4)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .clr(clr_b), .load(load_b),
        .load_val(load_val_b), .limit(limit_b), .one_shot(one_shot_b),
        .qOut(q_b), .tc(tc_b), .done(done_b), .ovf(ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [3:0] q, input logic t, input logic d, input logic o);
        check({tag, " q"},    q_a,    q);
        check({tag, " tc"},   tc_a,   t);
        check({tag, " done"}, done_a, d);
        check({tag, " ovf"},  ovf_a,  o);
    endtask

    logic [3:0] exp_q3   [8] = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    logic       exp_tc3  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    logic       exp_ovf3 [8] = '{0, 0, 0, 1, 1, 1, 1, 1};

    initial begin
        // Reset state, held across a couple of edges
        #1;
        check_a("reset", 4'd0, 0, 0, 0);
        check("reset b q", q_b, 4'd0);
        #16 rst = 1'b1;  // released at t=17, between edges

        // 1: wrap mode, limit 15
        en_a = 1;
        tick();
        check_a("t1 entry", 4'd0, 0, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check_a($sformatf("t1 step%0d", i), 4'(i), 0, 0, 0);
        end
        tick();
        check_a("t1 wrap", 4'd0, 1, 0, 1);
        tick();
        check_a("t1 after wrap", 4'd1, 0, 0, 1);

        // 2: one-shot to 9, then DONE holds with en still high
        clr_a = 1;
        tick();
        check_a("t2 clr", 4'd0, 0, 0, 0);
        clr_a = 0; one_shot_a = 1; limit_a = 4'd9;
        tick();
        check_a("t2 entry", 4'd0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_a($sformatf("t2 step%0d", i), 4'(i), 0, 0, 0);
        end
        tick();
        check_a("t2 reach", 4'd9, 1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_a($sformatf("t2 hold%0d", i), 4'd9, 0, 1, 0);
        end
        clr_a = 1;
        tick();
        check_a("t2 clr", 4'd0, 0, 0, 0);
        clr_a = 0;
        tick();
        check("t2 idle entry q", q_a, 4'd0);
        tick();
        check("t2 restart q", q_a, 4'd1);

        // 3: load above limit, run through rollover to the limit
        en_a = 0; one_shot_a = 0; limit_a = 4'd3; load_a = 1; load_val_a = 4'd12;
        tick();
        check_a("t3 load", 4'd12, 0, 0, 0);
        load_a = 0; en_a = 1;
        tick();
        check_a("t3 entry", 4'd12, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_a($sformatf("t3 seq%0d", i), exp_q3[i], exp_tc3[i], 0, exp_ovf3[i]);
        end

        // 4: asynchronous reset mid-cycle while running at 5 with ovf set
        limit_a = 4'd15; load_a = 1; load_val_a = 4'd0;
        tick();
        load_a = 0;
        tick();
        for (int i = 0; i < 5; i++) tick();
        check_a("t4 pre", 4'd5, 0, 0, 1);
        #2 rst = 1'b0;
        #1;
        check_a("t4 async", 4'd0, 0, 0, 0);
        rst = 1'b1;
        tick();
        check_a("t4 entry", 4'd0, 0, 0, 0);
        tick();
        check("t4 resume q", q_a, 4'd1);

        // 5: clr beats load; then load alone
        for (int i = 0; i < 3; i++) tick();
        check("t5 pre q", q_a, 4'd4);
        clr_a = 1; load_a = 1; load_val_a = 4'd7;
        tick();
        check("t5 clr+load q", q_a, 4'd0);
        clr_a = 0; load_a = 0;
        tick();
        check("t5 idle entry q", q_a, 4'd0);
        for (int i = 0; i < 4; i++) tick();
        check("t5 pre2 q", q_a, 4'd4);
        load_a = 1;
        tick();
        check("t5 load q", q_a, 4'd7);
        check("t5 load tc", tc_a, 1'b0);
        load_a = 0;
        tick();
        check("t5 idle entry2 q", q_a, 4'd7);
        tick();
        check("t5 resume q", q_a, 4'd8);
        en_a = 0;

        // 6: PRESCALE=4 instance; phase resets after dropping en mid-period
        en_b = 1;
        tick();
        check("t6 entry q", q_b, 4'd0);
        for (int s = 1; s <= 2; s++) begin
            for (int i = 0; i < 3; i++) tick();
            check($sformatf("t6 wait%0d q", s), q_b, 4'(s - 1));
            tick();
            check($sformatf("t6 step%0d q", s), q_b, 4'(s));
        end
        tick();
        tick();
        check("t6 mid q", q_b, 4'd2);
        en_b = 0;
        for (int i = 0; i < 3; i++) tick();
        check("t6 paused q", q_b, 4'd2);
        en_b = 1;
        tick();
        check("t6 reentry q", q_b, 4'd2);
        for (int i = 0; i < 3; i++) tick();
        check("t6 rephase q", q_b, 4'd2);
        tick();
        check("t6 step3 q", q_b, 4'd3);
        check("t6 tc", tc_b, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
